pwm_generator: RTL and testbench
================================

// Module: pwm_generator
//
// PURPOSE
// Center-aligned three-phase PWM stage directly downstream of svpwm. Takes per-phase
// duty words da_on/db_on/dc_on and turns them into complementary high/low gate drives
// with dead time. An up/down carrier counter is compared against double-buffered duties.
// Duties load only at the carrier valley, so a period never sees a mid-cycle duty change.
//
// PARAMETERS
// WIDTH      8  duty/counter width; carrier peak MAX = 2**WIDTH-1
// DEAD_TIME  4  dead-time in clk cycles (0 = no dead time); counter width $clog2(DEAD_TIME+1)
//
// PORTS
// clk         in   1      system clock, rising edge
// rst         in   1      asynchronous, active-high reset
// en          in   1      run enable; 0 = carrier held, all gates off
// duty_valid  in   1      1-cycle strobe: capture da_on/db_on/dc_on into pending regs
// da_on       in   WIDTH  phase A duty (unsigned, 0..MAX)
// db_on       in   WIDTH  phase B duty
// dc_on       in   WIDTH  phase C duty
// gate_hi     out  3      high-side drive, [0]=A [1]=B [2]=C
// gate_lo     out  3      low-side drive, same indexing
// cnt         out  WIDTH  carrier counter value
// sync        out  1      high while en && cnt==0 (valley); combinational from regs
//
// BEHAVIOUR
// Reset (async, immediate):
//  - cnt=0, dir=up; gate_hi=gate_lo=0; pending=0, pend_flag=0, active=0; dead-time ctrs=0.
// Carrier:
//  - While en, cnt steps 0,1..MAX,MAX-1..1,0,1..; period 2*MAX clks (510 @ WIDTH=8).
//  - dir flips at MAX and at 0.
//  - en=0: next edge forces cnt=0, dir=up, gates 0, dead-time ctrs 0; pending regs kept.
// Duty buffering:
//  - duty_valid edge: pending<=inputs, pend_flag<=1; later strobes overwrite (last wins).
//  - Edge with en && cnt==0: if pend_flag, active<=pending and pend_flag<=0.
//  - duty_valid on that same edge: inputs go straight to active; pend_flag<=0.
//  - First valley after en rises is an ordinary load point.
// Compare:
//  - ideal[i] = en && (cnt < active[i]) (unsigned).
//  - duty 0 = always low; duty MAX = low only while cnt==MAX (1 clk/period).
// Dead time, per phase, registered (1 clk latency from ideal):
//  - level[i] = committed state; equals 0 (low side) after reset.
//  - ideal==level: drive committed gate (hi if level=1 else lo), dt ctr cleared.
//  - ideal!=level: both gates 0, ctr++; on reaching DEAD_TIME, level<=ideal, ctr=0,
//    new gate on.
//  - Ideal reverts before DEAD_TIME: ctr clears, old gate resumes next edge.
//  - DEAD_TIME=0: gates follow ideal one clk later, no gap.
// Invariants:
//  - gate_hi[i] & gate_lo[i] never both 1, including reset release and en toggles.
//  - cnt never exceeds MAX.
//  - All widths unsigned; no overflow paths.
//
// TESTING (WIDTH=8, DEAD_TIME=4)
// 1. Assert rst mid-run -> gates, cnt, sync read 0 immediately; after release,
//    en=1 -> cnt 0,1,2..
// 2. All duties 128, en=1 -> per 510-clk period: ideal hi 255 clks, gate_hi 251,
//    gate_lo 251, 4-clk gaps.
// 3. Duty 0 -> gate_hi never 1. Duty 255 -> gate_hi drops for 1 clk at cnt==255,
//    gate_lo never 1.
// 4. duty_valid=64 at cnt=100 (up) -> active still old until valley edge;
//    next period uses 64.
// 5. duty_valid coincident with en&&cnt==0 -> new duty applies that period;
//    pend_flag ends 0.
// 6. Drop en at cnt=200, gate_hi=1 -> next edge gates 0, cnt 0; random stimulus
//    assertion hi&lo==0 always.

Source files
------------

// File: rtl/pwm_generator.sv
// Center-aligned three-phase PWM with valley-loaded double-buffered duties and
// per-phase dead-time insertion between complementary high/low gate drives.
//
// carrier direction | meaning
// DIR_UP            | counting 0 -> MAX, turns around after MAX
// DIR_DOWN          | counting MAX -> 0, turns around after 0
module pwm_generator #(
  parameter int WIDTH     = 8,
  parameter int DEAD_TIME = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             duty_valid,
  input  logic [WIDTH-1:0] da_on,
  input  logic [WIDTH-1:0] db_on,
  input  logic [WIDTH-1:0] dc_on,
  output logic [2:0]       gate_hi,
  output logic [2:0]       gate_lo,
  output logic [WIDTH-1:0] cnt,
  output logic             sync
);

  localparam logic [WIDTH-1:0] MAX     = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam int               DTW     = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
  localparam logic [DTW-1:0]   DT_LAST = DTW'(DEAD_TIME);
  localparam logic [DTW-1:0]   DT_ONE  = DTW'(1);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  dir_t                        dir_q, dir_d;
  logic [WIDTH-1:0]            cnt_q, cnt_d;
  logic [2:0][WIDTH-1:0]       pend_q, pend_d;
  logic [2:0][WIDTH-1:0]       act_q, act_d;
  logic                        pend_flag_q, pend_flag_d;
  logic [2:0]                  level_q, level_d;
  logic [2:0][DTW-1:0]         dt_q, dt_d;
  logic [2:0]                  gate_hi_q, gate_hi_d;
  logic [2:0]                  gate_lo_q, gate_lo_d;
  logic [2:0][WIDTH-1:0]       duty_in;
  logic [2:0]                  ideal;
  logic                        valley;

  assign duty_in = {dc_on, db_on, da_on};
  assign valley  = en && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q == MAX) begin
        cnt_d = cnt_q - ONE;
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      if (cnt_q == '0) begin
        cnt_d = cnt_q + ONE;
        dir_d = DIR_UP;
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end
  end

  // A strobe landing on the valley edge bypasses the pending buffer entirely.
  always_comb begin
    pend_d      = pend_q;
    act_d       = act_q;
    pend_flag_d = pend_flag_q;
    if (valley) begin
      if (duty_valid) begin
        act_d       = duty_in;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        act_d       = pend_q;
        pend_flag_d = 1'b0;
      end
    end else if (duty_valid) begin
      pend_d      = duty_in;
      pend_flag_d = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ideal[i] = en && (cnt_q < act_q[i]);
    end
  end

  always_comb begin
    level_d   = level_q;
    dt_d      = dt_q;
    gate_hi_d = '0;
    gate_lo_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (!en) begin
        level_d[i] = 1'b0;
        dt_d[i]    = '0;
      end else if (ideal[i] == level_q[i]) begin
        dt_d[i]      = '0;
        gate_hi_d[i] = level_q[i];
        gate_lo_d[i] = ~level_q[i];
      end else if (dt_q[i] == DT_LAST) begin
        level_d[i]   = ideal[i];
        dt_d[i]      = '0;
        gate_hi_d[i] = ideal[i];
        gate_lo_d[i] = ~ideal[i];
      end else begin
        dt_d[i] = dt_q[i] + DT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q       <= DIR_UP;
      cnt_q       <= '0;
      pend_q      <= '0;
      act_q       <= '0;
      pend_flag_q <= 1'b0;
      level_q     <= '0;
      dt_q        <= '0;
      gate_hi_q   <= '0;
      gate_lo_q   <= '0;
    end else begin
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      pend_flag_q <= pend_flag_d;
      level_q     <= level_d;
      dt_q        <= dt_d;
      gate_hi_q   <= gate_hi_d;
      gate_lo_q   <= gate_lo_d;
    end
  end

  assign gate_hi = gate_hi_q;
  assign gate_lo = gate_lo_q;
  assign cnt     = cnt_q;
  assign sync    = en && !rst && (cnt_q == '0);

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator (WIDTH=8, DEAD_TIME=4) with hand-computed
// expectations and a continuous no-shoot-through monitor.
module tb_pwm_generator;

  logic       clk;
  logic       rst;
  logic       en;
  logic       duty_valid;
  logic [7:0] da_on, db_on, dc_on;
  logic [2:0] gate_hi, gate_lo;
  logic [7:0] cnt;
  logic       sync;

  int checks   = 0;
  int failures = 0;
  bit inv_on   = 0;
  int hi_n[3], lo_n[3], gap_n[3];

  pwm_generator #(.WIDTH(8), .DEAD_TIME(4)) dut (
    .clk(clk), .rst(rst), .en(en), .duty_valid(duty_valid),
    .da_on(da_on), .db_on(db_on), .dc_on(dc_on),
    .gate_hi(gate_hi), .gate_lo(gate_lo), .cnt(cnt), .sync(sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int target, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      step();
      if (cnt == 8'(target)) hit = 1'b1;
    end
    check($sformatf("wait_cnt_%0d", target), 32'(hit), 32'd1);
  endtask

  task automatic measure();
    for (int p = 0; p < 3; p++) begin
      hi_n[p] = 0; lo_n[p] = 0; gap_n[p] = 0;
    end
    for (int k = 0; k < 510; k++) begin
      step();
      for (int p = 0; p < 3; p++) begin
        if (gate_hi[p]) hi_n[p]++;
        if (gate_lo[p]) lo_n[p]++;
        if (!gate_hi[p] && !gate_lo[p]) gap_n[p]++;
      end
    end
  endtask

  task automatic set_duty(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    da_on = a; db_on = b; dc_on = c;
  endtask

  always @(negedge clk) begin
    if (inv_on) begin
      checks++;
      assert ((gate_hi & gate_lo) === 3'b000) else begin
        failures++;
        $error("FAIL no_overlap: observed=%0b expected=000 (hi=%0b lo=%0b)",
               gate_hi & gate_lo, gate_hi, gate_lo);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; duty_valid = 1'b0;
    set_duty(8'd0, 8'd0, 8'd0);
    inv_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_hi", 32'(gate_hi), 32'd0);
    check("rst_lo", 32'(gate_lo), 32'd0);
    check("rst_sync", 32'(sync), 32'd0);
    rst = 1'b0;
    step();
    check("idle_hi", 32'(gate_hi), 32'd0);
    check("idle_lo", 32'(gate_lo), 32'd0);

    // pending loaded while disabled; first valley after enable is a load point
    duty_valid = 1'b1; set_duty(8'd128, 8'd128, 8'd128);
    step();
    duty_valid = 1'b0;
    en = 1'b1;
    #1;
    check("en_sync", 32'(sync), 32'd1);
    check("en_cnt0", 32'(cnt), 32'd0);
    step();
    check("c1_cnt", 32'(cnt), 32'd1);
    check("c1_lo", 32'(gate_lo), 32'd7);
    check("c1_hi", 32'(gate_hi), 32'd0);
    check("c1_sync", 32'(sync), 32'd0);
    step();
    check("c2_cnt", 32'(cnt), 32'd2);
    check("c2_gap_hi", 32'(gate_hi), 32'd0);
    check("c2_gap_lo", 32'(gate_lo), 32'd0);
    repeat (3) step();
    check("c5_cnt", 32'(cnt), 32'd5);
    check("c5_gap_hi", 32'(gate_hi), 32'd0);
    step();
    check("c6_cnt", 32'(cnt), 32'd6);
    check("c6_hi", 32'(gate_hi), 32'd7);
    check("c6_lo", 32'(gate_lo), 32'd0);

    measure();
    for (int p = 0; p < 3; p++) begin
      check($sformatf("d128_hi_%0d", p), 32'(hi_n[p]), 32'd251);
      check($sformatf("d128_lo_%0d", p), 32'(lo_n[p]), 32'd251);
      check($sformatf("d128_gap_%0d", p), 32'(gap_n[p]), 32'd8);
    end
    check("period_cnt", 32'(cnt), 32'd6);

    // mid-period strobe must not disturb the running period
    wait_cnt(100, 600);
    duty_valid = 1'b1; set_duty(8'd0, 8'd255, 8'd64);
    step();
    duty_valid = 1'b0;
    wait_cnt(255, 600);
    wait_cnt(50, 600);
    check("old_duty_hi", 32'(gate_hi), 32'd7);
    wait_cnt(0, 600);
    wait_cnt(255, 600);
    wait_cnt(0, 600);
    measure();
    check("d0_hi", 32'(hi_n[0]), 32'd0);
    check("d0_lo", 32'(lo_n[0]), 32'd510);
    check("d255_hi", 32'(hi_n[1]), 32'd509);
    check("d255_lo", 32'(lo_n[1]), 32'd0);
    check("d255_gap", 32'(gap_n[1]), 32'd1);
    check("d64_hi", 32'(hi_n[2]), 32'd123);
    check("d64_lo", 32'(lo_n[2]), 32'd379);
    check("d64_gap", 32'(gap_n[2]), 32'd8);

    // pending 10, then a strobe of 200 on the valley edge supersedes it
    wait_cnt(100, 600);
    duty_valid = 1'b1; set_duty(8'd10, 8'd10, 8'd10);
    step();
    duty_valid = 1'b0;
    wait_cnt(0, 600);
    check("valley_sync", 32'(sync), 32'd1);
    duty_valid = 1'b1; set_duty(8'd200, 8'd200, 8'd200);
    step();
    duty_valid = 1'b0;
    set_duty(8'd0, 8'd0, 8'd0);
    wait_cnt(150, 600);
    check("coinc_hi", 32'(gate_hi), 32'd7);
    wait_cnt(0, 600);
    wait_cnt(150, 600);
    check("coinc_next_hi", 32'(gate_hi), 32'd7);
    check("coinc_next_lo", 32'(gate_lo), 32'd0);

    wait_cnt(200, 600);
    check("pre_drop_hi", 32'(gate_hi), 32'd7);
    en = 1'b0;
    step();
    check("drop_cnt", 32'(cnt), 32'd0);
    check("drop_hi", 32'(gate_hi), 32'd0);
    check("drop_lo", 32'(gate_lo), 32'd0);

    en = 1'b1;
    wait_cnt(50, 600);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_cnt", 32'(cnt), 32'd0);
    check("mid_rst_hi", 32'(gate_hi), 32'd0);
    check("mid_rst_lo", 32'(gate_lo), 32'd0);
    check("mid_rst_sync", 32'(sync), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("rel_sync", 32'(sync), 32'd1);
    step();
    check("rel_cnt1", 32'(cnt), 32'd1);
    step();
    check("rel_cnt2", 32'(cnt), 32'd2);

    for (int k = 0; k < 3000; k++) begin
      en         = ($urandom_range(0, 15) != 0);
      duty_valid = ($urandom_range(0, 3) == 0);
      set_duty(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)));
      step();
    end
    duty_valid = 1'b0;
    step();
    inv_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
